// File: rtl/alu2_pkg.sv
// Shared constants and types for the two-requester 2-bit ALU scheduler.
package alu2_pkg;
  localparam int RES_W = 4;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Operands and opcode captured from the winning requester.
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
  } alu_req_t;
endpackage

// File: rtl/alu2_core.sv
// Purely combinational 2-bit ALU producing a zero-extended 4-bit result.
module alu2_core
  import alu2_pkg::*;
(
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic [1:0]       op,
  output logic [RES_W-1:0] y
);
  logic [2:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD:  y = {1'b0, sum};
      OP_MUL:  y = {2'b00, a} * {2'b00, b};
      OP_NAND: y = {2'b00, ~(a & b)};
      OP_NOTA: y = {2'b00, ~a};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu2_sched.sv
// Arbitrates two requesters onto one shared ALU; result held on a valid/ready port.
module alu2_sched
  import alu2_pkg::*;
#(
  parameter bit FAIR      = 1'b1,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Req,
  input  logic [1:0]       A0,
  input  logic [1:0]       B0,
  input  logic [1:0]       Op0,
  input  logic [1:0]       A1,
  input  logic [1:0]       B1,
  input  logic [1:0]       Op1,
  output logic [1:0]       Ack,
  output logic [RES_W-1:0] Result,
  output logic             ResId,
  output logic             ResValid,
  input  logic             ResReady,
  output logic             Busy
);
  state_t           state, nxt;
  logic             sel, gsel, rr;
  alu_req_t         lat;
  logic [RES_W-1:0] y;

  alu2_core u_core (
    .a  (lat.a),
    .b  (lat.b),
    .op (lat.op),
    .y  (y)
  );

  // Tie-break: round-robin pointer when fair, otherwise requester 0.
  always_comb begin
    gsel = 1'b0;
    unique case (Req)
      2'b01:   gsel = 1'b0;
      2'b10:   gsel = 1'b1;
      2'b11:   gsel = FAIR ? rr : 1'b0;
      default: gsel = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (Req != 2'b00) nxt = ST_EXEC;
      ST_EXEC: nxt = ST_HOLD;
      ST_HOLD: if (ResReady) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lat    <= '0;
      sel    <= 1'b0;
      rr     <= PRIO_INIT;
      Result <= '0;
      ResId  <= 1'b0;
    end else begin
      if (state == ST_IDLE && Req != 2'b00) begin
        sel <= gsel;
        lat <= gsel ? '{a: A1, b: B1, op: Op1} : '{a: A0, b: B0, op: Op0};
        if (FAIR) rr <= ~gsel;
      end
      if (state == ST_EXEC) begin
        Result <= y;
        ResId  <= sel;
      end
    end
  end

  assign Ack      = (state == ST_EXEC) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign ResValid = (state == ST_HOLD);
  assign Busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_alu2_sched.sv
// Bench for alu2_sched: a fair and a fixed-priority instance share one stimulus stream.
module tb_alu2_sched;
  import alu2_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, ResReady;
  logic [1:0] Req, A0, B0, Op0, A1, B1, Op1;
  logic [1:0] ack_f, ack_p;
  logic [3:0] res_f, res_p;
  logic       id_f, id_p, vld_f, vld_p, busy_f, busy_p;

  always #5 Clk = ~Clk;

  alu2_sched #(.FAIR(1'b1), .PRIO_INIT(1'b0)) u_fair (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .A0(A0), .B0(B0), .Op0(Op0), .A1(A1), .B1(B1), .Op1(Op1),
    .Ack(ack_f), .Result(res_f), .ResId(id_f), .ResValid(vld_f),
    .ResReady(ResReady), .Busy(busy_f)
  );

  alu2_sched #(.FAIR(1'b0), .PRIO_INIT(1'b0)) u_prio (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .A0(A0), .B0(B0), .Op0(Op0), .A1(A1), .B1(B1), .Op1(Op1),
    .Ack(ack_p), .Result(res_p), .ResId(id_p), .ResValid(vld_p),
    .ResReady(ResReady), .Busy(busy_p)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: index 0 = fair instance, 1 = fixed priority.
  bit         rr_m [2];
  bit         e_w  [2];
  logic [3:0] e_res[2];

  logic [1:0] o_ack[2], o_ack_hold[2];
  logic [3:0] o_res[2];
  logic       o_id[2], o_vld[2], o_busy_exec[2], o_stable[2], o_post_vld[2], o_post_busy[2];

  function automatic bit win(logic [1:0] rq, bit rr, bit fair);
    if (rq == 2'b01) return 1'b0;
    if (rq == 2'b10) return 1'b1;
    return fair ? rr : 1'b0;
  endfunction

  function automatic logic [3:0] ref_alu(int a, int b, int op);
    case (op)
      0:       return 4'(a + b);
      1:       return 4'(a * b);
      2:       return 4'(3 - (a & b));
      default: return 4'(3 - a);
    endcase
  endfunction

  // Drives one full operation from IDLE back to IDLE and records observations.
  task automatic run_op(input logic [1:0] rq, input logic [1:0] a0, b0, op0, a1, b1, op1,
                        input int hold, input bit chg, input logic [1:0] new_a0);
    Req = rq; A0 = a0; B0 = b0; Op0 = op0; A1 = a1; B1 = b1; Op1 = op1;
    ResReady = (hold == 0);
    for (int k = 0; k < 2; k++) begin
      e_w[k]   = win(rq, rr_m[k], k == 0);
      e_res[k] = e_w[k] ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
    end
    rr_m[0] = ~e_w[0];
    @(posedge Clk); @(negedge Clk);
    o_ack[0] = ack_f; o_ack[1] = ack_p; o_busy_exec[0] = busy_f; o_busy_exec[1] = busy_p;
    @(posedge Clk); @(negedge Clk);
    o_res[0] = res_f; o_res[1] = res_p; o_id[0] = id_f; o_id[1] = id_p;
    o_vld[0] = vld_f; o_vld[1] = vld_p; o_ack_hold[0] = ack_f; o_ack_hold[1] = ack_p;
    if (chg) A0 = new_a0;
    o_stable[0] = 1'b1; o_stable[1] = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); @(negedge Clk);
      if (res_f !== o_res[0] || id_f !== o_id[0] || vld_f !== 1'b1 || busy_f !== 1'b1 || ack_f !== 2'b00)
        o_stable[0] = 1'b0;
      if (res_p !== o_res[1] || id_p !== o_id[1] || vld_p !== 1'b1 || busy_p !== 1'b1 || ack_p !== 2'b00)
        o_stable[1] = 1'b0;
      if (i == hold - 1) ResReady = 1'b1;
    end
    @(posedge Clk); @(negedge Clk);
    o_post_vld[0] = vld_f; o_post_vld[1] = vld_p; o_post_busy[0] = busy_f; o_post_busy[1] = busy_p;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ResReady = 1'b0; Req = 2'b11;
    A0 = 2'd1; B0 = 2'd1; Op0 = OP_ADD; A1 = 2'd1; B1 = 2'd1; Op1 = OP_ADD;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({ack_f, res_f, id_f, vld_f, busy_f} !== 9'd0) begin
      n_err++; $display("FAIL reset_fair: got %b want 0", {ack_f, res_f, id_f, vld_f, busy_f});
    end
    n_cmp++;
    if ({ack_p, res_p, id_p, vld_p, busy_p} !== 9'd0) begin
      n_err++; $display("FAIL reset_prio: got %b want 0", {ack_p, res_p, id_p, vld_p, busy_p});
    end
    Reset = 1'b0; Req = 2'b00;
    rr_m[0] = 1'b0; rr_m[1] = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_single();
    run_op(2'b01, 2'd3, 2'd3, OP_MUL, 2'd0, 2'd0, OP_ADD, 0, 1'b0, 2'd0);
    Req = 2'b00;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_ack[k] !== 2'b01 || o_busy_exec[k] !== 1'b1) begin
        n_err++; $display("FAIL single_ack dut%0d: got ack=%b busy=%b want 01/1", k, o_ack[k], o_busy_exec[k]);
      end
      n_cmp++;
      if (o_res[k] !== 4'd9 || o_id[k] !== 1'b0 || o_vld[k] !== 1'b1 || o_ack_hold[k] !== 2'b00) begin
        n_err++; $display("FAIL single_res dut%0d: got res=%0d id=%b vld=%b ack=%b want 9/0/1/00",
                          k, o_res[k], o_id[k], o_vld[k], o_ack_hold[k]);
      end
      n_cmp++;
      if (o_post_vld[k] !== 1'b0 || o_post_busy[k] !== 1'b0) begin
        n_err++; $display("FAIL single_idle dut%0d: got vld=%b busy=%b want 0/0", k, o_post_vld[k], o_post_busy[k]);
      end
    end
  endtask

  task automatic test_opcode_sweep();
    logic [1:0] ops [4] = '{OP_ADD, OP_NAND, OP_NOTA, OP_MUL};
    logic [1:0] aa  [4] = '{2'd2, 2'd2, 2'd2, 2'd3};
    logic [1:0] bb  [4] = '{2'd3, 2'd3, 2'd3, 2'd2};
    logic [3:0] want[4] = '{4'd5, 4'd1, 4'd1, 4'd6};
    for (int t = 0; t < 4; t++) begin
      run_op(2'b10, 2'd0, 2'd0, OP_ADD, aa[t], bb[t], ops[t], 0, 1'b0, 2'd0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_res[k] !== want[t] || o_id[k] !== 1'b1 || o_ack[k] !== 2'b10) begin
          n_err++; $display("FAIL sweep_op%0d dut%0d: got res=%0d id=%b ack=%b want %0d/1/10",
                            ops[t], k, o_res[k], o_id[k], o_ack[k], want[t]);
        end
      end
    end
    Req = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    ResReady = 1'b1; Req = 2'b01; A0 = 2'd3; B0 = 2'd3; Op0 = OP_MUL;
    @(posedge Clk); @(negedge Clk);
    n_cmp++;
    if (ack_f !== 2'b01 || busy_f !== 1'b1) begin
      n_err++; $display("FAIL midrst_exec: got ack=%b busy=%b want 01/1", ack_f, busy_f);
    end
    Reset = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Reset = 1'b0; Req = 2'b00;
    rr_m[0] = 1'b0; rr_m[1] = 1'b0;
    n_cmp++;
    if ({ack_f, res_f, id_f, vld_f, busy_f} !== 9'd0 || {ack_p, res_p, id_p, vld_p, busy_p} !== 9'd0) begin
      n_err++; $display("FAIL midrst_clear: got f=%b p=%b want 0", {ack_f, res_f, id_f, vld_f, busy_f},
                        {ack_p, res_p, id_p, vld_p, busy_p});
    end
    @(posedge Clk); @(negedge Clk);
    n_cmp++;
    if (vld_f !== 1'b0 || busy_f !== 1'b0 || ack_f !== 2'b00) begin
      n_err++; $display("FAIL midrst_dropped: got vld=%b busy=%b ack=%b want 0/0/00", vld_f, busy_f, ack_f);
    end
  endtask

  task automatic test_contention();
    bit want_f [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit want_p [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 5; t++) begin
      run_op((t < 4) ? 2'b11 : 2'b10, 2'd1, 2'd2, OP_ADD, 2'd3, 2'd3, OP_MUL, 0, 1'b0, 2'd0);
      n_cmp++;
      if (o_ack[0] !== (want_f[t] ? 2'b10 : 2'b01) || o_ack_hold[0] !== 2'b00 || o_id[0] !== want_f[t]) begin
        n_err++; $display("FAIL contend_fair_%0d: got ack=%b id=%b want id %b single pulse", t, o_ack[0], o_id[0], want_f[t]);
      end
      n_cmp++;
      if (o_ack[1] !== (want_p[t] ? 2'b10 : 2'b01) || o_ack_hold[1] !== 2'b00 || o_id[1] !== want_p[t]) begin
        n_err++; $display("FAIL contend_prio_%0d: got ack=%b id=%b want id %b single pulse", t, o_ack[1], o_id[1], want_p[t]);
      end
      n_cmp++;
      if (o_res[0] !== e_res[0] || o_res[1] !== e_res[1]) begin
        n_err++; $display("FAIL contend_res_%0d: got %0d/%0d want %0d/%0d", t, o_res[0], o_res[1], e_res[0], e_res[1]);
      end
    end
    Req = 2'b00;
  endtask

  task automatic test_backpressure();
    run_op(2'b11, 2'd2, 2'd2, OP_MUL, 2'd1, 2'd3, OP_ADD, 5, 1'b0, 2'd0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_stable[k] !== 1'b1 || o_res[k] !== e_res[k] || o_id[k] !== e_w[k]) begin
        n_err++; $display("FAIL bp_hold dut%0d: got stable=%b res=%0d id=%b want 1/%0d/%b",
                          k, o_stable[k], o_res[k], o_id[k], e_res[k], e_w[k]);
      end
      n_cmp++;
      if (o_post_vld[k] !== 1'b0 || o_post_busy[k] !== 1'b0) begin
        n_err++; $display("FAIL bp_release dut%0d: got vld=%b busy=%b want 0/0", k, o_post_vld[k], o_post_busy[k]);
      end
    end
    run_op(2'b11, 2'd2, 2'd2, OP_MUL, 2'd1, 2'd3, OP_ADD, 0, 1'b0, 2'd0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_ack[k] !== (e_w[k] ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL bp_next_ack dut%0d: got %b want id %b", k, o_ack[k], e_w[k]);
      end
    end
    Req = 2'b00;
  endtask

  task automatic test_operand_change();
    run_op(2'b01, 2'd1, 2'd2, OP_ADD, 2'd0, 2'd0, OP_ADD, 3, 1'b1, 2'd3);
    Req = 2'b00;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_res[k] !== 4'd3 || o_stable[k] !== 1'b1) begin
        n_err++; $display("FAIL opchg dut%0d: got res=%0d stable=%b want 3/1", k, o_res[k], o_stable[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_op(2'($urandom_range(3, 1)), 2'($urandom), 2'($urandom), 2'($urandom),
             2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(2, 0), 1'b0, 2'd0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_ack[k] !== (e_w[k] ? 2'b10 : 2'b01) || o_res[k] !== e_res[k] || o_id[k] !== e_w[k] ||
            o_vld[k] !== 1'b1 || o_stable[k] !== 1'b1 || o_post_vld[k] !== 1'b0) begin
          n_err++; $display("FAIL rand_%0d dut%0d: got ack=%b res=%0d id=%b vld=%b want id %b res %0d",
                            t, k, o_ack[k], o_res[k], o_id[k], o_vld[k], e_w[k], e_res[k]);
        end
      end
    end
    Req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcode_sweep();
    test_reset_mid_op();
    test_contention();
    test_backpressure();
    test_operand_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
